// File: rtl/present_pkg.sv
// Shared types and constants for the PRESENT word-serial front end.
package present_pkg;

  localparam int PRESENT_BLK_W = 64;
  localparam int PRESENT_KEY_W = 80;
  localparam int WORD_W        = 32;
  // Width of the top key slice carried by the first key word.
  localparam int KEY_TOP_W     = PRESENT_KEY_W - 2 * WORD_W;

  // Header word bit positions.
  localparam int MODE_BIT   = 0;
  localparam int NEWKEY_BIT = 1;

  typedef enum logic [3:0] {
    ST_HDR,
    ST_KEY0,
    ST_KEY1,
    ST_KEY2,
    ST_DAT0,
    ST_DAT1,
    ST_LAUNCH,
    ST_WAIT,
    ST_OUT_HI,
    ST_OUT_LO
  } state_t;

  // States in which an input word may be accepted.
  function automatic logic isInputState(input state_t s);
    return (s == ST_HDR)  || (s == ST_KEY0) || (s == ST_KEY1) ||
           (s == ST_KEY2) || (s == ST_DAT0) || (s == ST_DAT1);
  endfunction

  // States in which a result word is presented.
  function automatic logic isOutputState(input state_t s);
    return (s == ST_OUT_HI) || (s == ST_OUT_LO);
  endfunction

endpackage

// File: rtl/present_stream_ctrl.sv
// Word-serial command front end for a PRESENT-80 core: gathers header, optional
// key and block words, launches one operation, waits for the core, and streams
// the 64-bit result back as two 32-bit words.
module present_stream_ctrl
  import present_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     iReset,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic [WORD_W-1:0]        iData,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [WORD_W-1:0]        oData,
  output logic                     oBusy,
  output logic                     oErr,
  output logic [PRESENT_BLK_W-1:0] oCoreDat,
  output logic [PRESENT_KEY_W-1:0] oCoreKey,
  output logic                     oCoreCtrl,
  output logic                     oCoreLoad,
  output logic                     oCoreRst_n,
  input  logic                     iCoreDone,
  input  logic [PRESENT_BLK_W-1:0] iCoreDat
);

  localparam int               CNT_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  state_t                   r_state;
  state_t                   w_stateNext;
  logic                     r_mode;
  logic [PRESENT_KEY_W-1:0] r_key;
  logic [WORD_W-1:0]        r_blkHi;
  logic [WORD_W-1:0]        r_resultLo;
  logic                     r_armed;
  logic [CNT_W-1:0]         r_cnt;

  logic                     w_inHs;
  logic                     w_outHs;
  logic                     w_complete;
  logic                     w_timeout;
  logic [CNT_W-1:0]         w_cntNext;

  // The core shares our reset, inverted to its active-low convention.
  assign oCoreRst_n = ~iReset;

  assign w_inHs     = iValid & oReady;
  assign w_outHs    = oValid & iReady;
  // A done only counts once the core has been seen low during this wait,
  // so a done still high from the previous operation is ignored.
  assign w_complete = r_armed & iCoreDone;
  assign w_cntNext  = r_cnt + CNT_W'(1);
  assign w_timeout  = (w_cntNext == TIMEOUT_VAL);

  // Next-state decode; all outputs are registered from this in the FSM block.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_HDR:    if (w_inHs) w_stateNext = iData[NEWKEY_BIT] ? ST_KEY0 : ST_DAT0;
      ST_KEY0:   if (w_inHs) w_stateNext = ST_KEY1;
      ST_KEY1:   if (w_inHs) w_stateNext = ST_KEY2;
      ST_KEY2:   if (w_inHs) w_stateNext = ST_DAT0;
      ST_DAT0:   if (w_inHs) w_stateNext = ST_DAT1;
      ST_DAT1:   if (w_inHs) w_stateNext = ST_LAUNCH;
      ST_LAUNCH: w_stateNext = ST_WAIT;
      ST_WAIT:   if (w_complete || w_timeout) w_stateNext = ST_OUT_HI;
      ST_OUT_HI: if (w_outHs) w_stateNext = ST_OUT_LO;
      ST_OUT_LO: if (w_outHs) w_stateNext = ST_HDR;
      default:   w_stateNext = ST_HDR;
    endcase
  end

  // Control FSM: state, operand assembly, wait/timeout and result streaming.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      r_state    <= ST_HDR;
      r_mode     <= 1'b0;
      r_key      <= '0;
      r_blkHi    <= '0;
      r_resultLo <= '0;
      r_armed    <= 1'b0;
      r_cnt      <= '0;
      oReady     <= 1'b1;
      oValid     <= 1'b0;
      oData      <= '0;
      oBusy      <= 1'b0;
      oErr       <= 1'b0;
      oCoreDat   <= '0;
      oCoreKey   <= '0;
      oCoreCtrl  <= 1'b0;
      oCoreLoad  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      oReady    <= isInputState(w_stateNext);
      oValid    <= isOutputState(w_stateNext);
      oBusy     <= (w_stateNext != ST_HDR);
      oCoreLoad <= (w_stateNext == ST_LAUNCH);
      oErr      <= 1'b0;
      case (r_state)
        ST_HDR:  if (w_inHs) r_mode <= iData[MODE_BIT];
        ST_KEY0: if (w_inHs) r_key[PRESENT_KEY_W-1 -: KEY_TOP_W] <= iData[KEY_TOP_W-1:0];
        ST_KEY1: if (w_inHs) r_key[2*WORD_W-1 -: WORD_W] <= iData;
        ST_KEY2: if (w_inHs) r_key[WORD_W-1:0] <= iData;
        ST_DAT0: if (w_inHs) r_blkHi <= iData;
        ST_DAT1: begin
          // Core operands change only here, so they hold steady for the whole
          // operation and the previous key is reused when no key words came.
          if (w_inHs) begin
            oCoreDat  <= {r_blkHi, iData};
            oCoreKey  <= r_key;
            oCoreCtrl <= r_mode;
          end
        end
        ST_LAUNCH: begin
          r_cnt   <= '0;
          r_armed <= 1'b0;
        end
        ST_WAIT: begin
          r_cnt <= w_cntNext;
          if (!iCoreDone) r_armed <= 1'b1;
          if (w_complete) begin
            oData      <= iCoreDat[PRESENT_BLK_W-1 -: WORD_W];
            r_resultLo <= iCoreDat[WORD_W-1:0];
          end else if (w_timeout) begin
            oData      <= '1;
            r_resultLo <= '1;
            oErr       <= 1'b1;
          end
        end
        ST_OUT_HI: if (w_outHs) oData <= r_resultLo;
        ST_OUT_LO: if (w_outHs) oData <= '0;
        default: ;
      endcase
    end
  end

endmodule
